// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
// Module : sram_pkg
// Shared constants and FSM state encoding for the SRAM controller and SRAM.
// Rev    : 1.0  initial release
// ============================================================================
package sram_pkg;

    localparam int DEF_DEPTH  = 8;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_RWAIT = 3'd3,
        ST_CLEAR = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sram_sweep_cnt.sv
`default_nettype none
// ============================================================================
// Module : sram_sweep_cnt
// DEPTH-bounded up-counter with clear, enable and terminal-count flag.
// Rev    : 1.0  initial release
// ============================================================================
module sram_sweep_cnt
    import sram_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    assign tc = (count == CNT_W'(DEPTH - 1));

    // Saturates at DEPTH-1 so a late enable cannot wrap into a second pass
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !tc) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module : sram_ctrl
// Valid/ready request front end and clear sweeper for a synchronous SRAM.
// Rev    : 1.0  initial release
// ============================================================================
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int                DEPTH     = DEF_DEPTH,
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter int                DATA_W    = DEF_DATA_W,
    parameter logic [DATA_W-1:0] CLR_VALUE = '0
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              wr_err,
    input  logic              clr_start,
    output logic              clr_done,
    output logic              busy,
    output logic [ADDR_W-1:0] Addr,
    output logic              CS,
    output logic              WE,
    output logic              RD,
    output logic [DATA_W-1:0] dataIn,
    input  logic [DATA_W-1:0] dataOut
);

    localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_oor;
    logic              w_oor;
    logic              w_in_range;
    logic [31:0]       w_addr_ext;
    logic              w_cnt_clr;
    logic              w_cnt_en;
    logic [CNT_W-1:0]  w_cnt;
    logic              w_cnt_tc;
    logic              w_cs;
    logic              w_we;
    logic              w_rd;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_din;
    logic              w_rsp_valid;
    logic [DATA_W-1:0] w_rsp_data;
    logic              w_rsp_err;
    logic              w_wr_err;
    logic              w_clr_done;

    sram_sweep_cnt #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_sweep_cnt (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .clr   (w_cnt_clr),
        .en    (w_cnt_en),
        .count (w_cnt),
        .tc    (w_cnt_tc)
    );

    assign w_addr_ext = 32'(req_addr);
    assign w_in_range = (w_addr_ext < 32'(DEPTH));

    // A pending clear start hides the request port for that cycle
    assign req_ready = Rst_n && (r_state == ST_IDLE) && !clr_start;
    assign busy      = (r_state != ST_IDLE);

    always_comb begin
        w_state_next = r_state;
        w_oor        = r_oor;
        w_cnt_clr    = 1'b0;
        w_cnt_en     = 1'b0;
        w_cs         = 1'b0;
        w_we         = 1'b0;
        w_rd         = 1'b0;
        w_addr       = Addr;
        w_din        = dataIn;
        w_rsp_valid  = 1'b0;
        w_rsp_data   = rsp_data;
        w_rsp_err    = 1'b0;
        w_wr_err     = 1'b0;
        w_clr_done   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (clr_start) begin
                    w_state_next = ST_CLEAR;
                    w_cnt_clr    = 1'b1;
                    w_cs         = 1'b1;
                    w_we         = 1'b1;
                    w_addr       = '0;
                    w_din        = CLR_VALUE;
                end else if (req_valid) begin
                    w_oor  = !w_in_range;
                    w_addr = req_addr;
                    w_cs   = w_in_range;
                    if (req_we) begin
                        w_state_next = ST_WRITE;
                        w_we         = w_in_range;
                        w_din        = req_wdata;
                    end else begin
                        w_state_next = ST_READ;
                        w_rd         = w_in_range;
                    end
                end
            end
            ST_WRITE: begin
                w_state_next = ST_IDLE;
                w_wr_err     = r_oor;
                w_rsp_err    = r_oor;
            end
            ST_READ: begin
                w_state_next = ST_RWAIT;
            end
            ST_RWAIT: begin
                w_state_next = ST_IDLE;
                w_rsp_valid  = 1'b1;
                w_rsp_err    = r_oor;
                w_rsp_data   = r_oor ? '0 : dataOut;
            end
            ST_CLEAR: begin
                // Counter mirrors the address on the pins; advance it in lockstep
                if (w_cnt_tc) begin
                    w_state_next = ST_IDLE;
                    w_clr_done   = 1'b1;
                end else begin
                    w_cnt_en = 1'b1;
                    w_cs     = 1'b1;
                    w_we     = 1'b1;
                    w_addr   = ADDR_W'(w_cnt) + ADDR_W'(1);
                    w_din    = CLR_VALUE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_state   <= ST_IDLE;
            r_oor     <= 1'b0;
            Addr      <= '0;
            CS        <= 1'b0;
            WE        <= 1'b0;
            RD        <= 1'b0;
            dataIn    <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            wr_err    <= 1'b0;
            clr_done  <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_oor     <= w_oor;
            Addr      <= w_addr;
            CS        <= w_cs;
            WE        <= w_we;
            RD        <= w_rd;
            dataIn    <= w_din;
            rsp_valid <= w_rsp_valid;
            rsp_data  <= w_rsp_data;
            rsp_err   <= w_rsp_err;
            wr_err    <= w_wr_err;
            clr_done  <= w_clr_done;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_sram_ctrl
// Scoreboard bench for sram_ctrl with a behavioural 8-word SRAM.
// Rev    : 1.0  initial release
// ============================================================================
module tb_sram_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_we = 1'b0;
    logic [7:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       wr_err;
    logic       clr_start = 1'b0;
    logic       clr_done;
    logic       busy;
    logic [7:0] addr;
    logic       cs;
    logic       we;
    logic       rd;
    logic [7:0] data_in;
    logic [7:0] data_out = '0;

    sram_ctrl #(
        .DEPTH     (8),
        .ADDR_W    (8),
        .DATA_W    (8),
        .CLR_VALUE (8'h00)
    ) dut (
        .Clk       (clk),
        .Rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .wr_err    (wr_err),
        .clr_start (clr_start),
        .clr_done  (clr_done),
        .busy      (busy),
        .Addr      (addr),
        .CS        (cs),
        .WE        (we),
        .RD        (rd),
        .dataIn    (data_in),
        .dataOut   (data_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         acc;
    } exp_t;

    exp_t       sb[$];
    int         wr_q[$];
    logic [7:0] mem [8];
    logic [7:0] model [8];
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    int         viol = 0;
    int         wr_cycles = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SRAM: writes and registered reads on the rising edge
    always @(posedge clk) begin
        if (cs && we && addr < 8) mem[addr[2:0]] <= data_in;
        if (cs && rd && addr < 8) data_out <= mem[addr[2:0]];
    end

    // Monitor: pin protocol plus scoreboard pops on every response pulse
    always @(negedge clk) begin
        exp_t e;
        int   a;
        if (we && rd) viol++;
        if (cs && addr >= 8) viol++;
        if (cs && we) wr_cycles++;
        if (rsp_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rsp: got data=%h err=%b at cycle %0d, required no response", rsp_data, rsp_err, cyc);
            end else begin
                e = sb.pop_front();
                if (rsp_data !== e.data || rsp_err !== e.err || (cyc - e.acc) != 2) begin
                    errors++;
                    $display("FAIL rsp: got data=%h err=%b lat=%0d, required data=%h err=%b lat=2",
                             rsp_data, rsp_err, cyc - e.acc, e.data, e.err);
                end
            end
        end
        if (wr_err) begin
            checks++;
            if (wr_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_wr_err: got wr_err=1 at cycle %0d, required 0", cyc);
            end else begin
                a = wr_q.pop_front();
                if (rsp_err !== 1'b1 || (cyc - a) != 1) begin
                    errors++;
                    $display("FAIL wr_err: got rsp_err=%b lat=%0d, required rsp_err=1 lat=1", rsp_err, cyc - a);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    // Present a request at a falling edge; returns the edge number of acceptance
    task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] d, output int acc);
        exp_t e;
        int   t;
        req_we    = w;
        req_addr  = a;
        req_wdata = d;
        req_valid = 1'b1;
        t = 0;
        while (!req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc + 1;
        if (w) begin
            if (a < 8) model[a[2:0]] = d;
            else wr_q.push_back(acc);
        end else begin
            e.data = (a < 8) ? model[a[2:0]] : 8'h00;
            e.err  = (a >= 8);
            e.acc  = acc;
            sb.push_back(e);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (busy) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic run_clear(input int exp_len);
        int n;
        int w0;
        int t;
        #1 w0 = wr_cycles;
        @(negedge clk);
        clr_start = 1'b1;
        n = cyc + 1;
        @(negedge clk);
        clr_start = 1'b0;
        for (int i = 0; i < 8; i++) model[i] = 8'h00;
        t = 0;
        while (!clr_done && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("clr_done_seen", 32'(clr_done), 32'd1);
        chk("clr_done_latency", 32'(cyc - n), 32'(exp_len));
        #1 chk("clear_write_cycles", 32'(wr_cycles - w0), 32'(exp_len));
    endtask

    initial begin
        int acc;
        int prev;
        int n;
        for (int i = 0; i < 8; i++) begin
            mem[i]   = 8'h00;
            model[i] = 8'h00;
        end

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs", 32'({rsp_valid, rsp_data, rsp_err, wr_err, clr_done, busy,
                                  addr, cs, we, rd, data_in}), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("ready_after_reset", 32'(req_ready), 32'd1);
        chk("busy_after_reset", 32'(busy), 32'd0);
        @(negedge clk);

        // Write then read back
        issue(1'b1, 8'd3, 8'hA5, acc);
        issue(1'b0, 8'd3, 8'h00, acc);

        // Back-to-back alternating traffic: write gap 2, read gap 3
        wait_idle();
        prev = -1;
        for (int i = 0; i < 8; i++) begin
            issue(1'b1, 8'(i), 8'h10 + 8'(i * 7), acc);
            if (prev >= 0) chk("gap_after_read", 32'(acc - prev), 32'd3);
            prev = acc;
            issue(1'b0, 8'(i), 8'h00, acc);
            chk("gap_after_write", 32'(acc - prev), 32'd2);
            prev = acc;
        end

        // Fill with FF, then clear sweep and read back the last word
        wait_idle();
        for (int i = 0; i < 8; i++) issue(1'b1, 8'(i), 8'hFF, acc);
        wait_idle();
        run_clear(8);
        issue(1'b0, 8'd7, 8'h00, acc);

        // Clear start wins over a simultaneous request
        wait_idle();
        req_we    = 1'b1;
        req_addr  = 8'd2;
        req_wdata = 8'h3C;
        req_valid = 1'b1;
        clr_start = 1'b1;
        #1 chk("ready_low_on_clr_start", 32'(req_ready), 32'd0);
        n = cyc + 1;
        @(negedge clk);
        clr_start = 1'b0;
        for (int i = 0; i < 8; i++) model[i] = 8'h00;
        issue(1'b1, 8'd2, 8'h3C, acc);
        chk("deferred_accept_edge", 32'(acc - n), 32'd9);
        issue(1'b0, 8'd2, 8'h00, acc);

        // Out-of-range read and write
        wait_idle();
        issue(1'b0, 8'd8, 8'h00, acc);
        chk("oor_read_cs", 32'(cs), 32'd0);
        issue(1'b1, 8'd200, 8'h77, acc);
        issue(1'b0, 8'd0, 8'h00, acc);

        // Reset during RWAIT abandons the read
        wait_idle();
        issue(1'b0, 8'd2, 8'h00, acc);
        @(negedge clk);
        rst_n = 1'b0;
        void'(sb.pop_back());
        @(negedge clk);
        chk("midop_reset_outputs", 32'({req_ready, rsp_valid, rsp_data, rsp_err, wr_err, clr_done,
                                        busy, addr, cs, we, rd, data_in}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("ready_after_midop_reset", 32'(req_ready), 32'd1);
        @(negedge clk);
        issue(1'b0, 8'd2, 8'h00, acc);

        wait_idle();
        repeat (4) @(negedge clk);
        chk("pending_rsp", 32'(sb.size()), 32'd0);
        chk("pending_wr_err", 32'(wr_q.size()), 32'd0);
        chk("pin_protocol_violations", 32'(viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
